// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared types and helpers for the bit-serial adder controller.
//                Holds the FSM state encoding, the default operand width and
//                the bit-counter width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold 0..WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder_1.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_1
//  Description : Combinational 1-bit full adder.
//  Ports       : i_a, i_b, i_Cin  - addend bits and carry-in
//                o_s              - sum bit
//                o_Cout           - carry-out
//  Revision    : 1.0  initial release
// ============================================================================
module full_adder_1 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_Cin,
    output logic o_s,
    output logic o_Cout
);

    assign o_s    = i_a ^ i_b ^ i_Cin;
    assign o_Cout = (i_a & i_b) | (i_Cin & (i_a ^ i_b));

endmodule
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_ctrl
//  Description : Bit-serial adder. Captures A, B and carry-in on an accepted
//                start, adds one bit per cycle LSB first through a single
//                full-adder slice, and publishes sum, carry-out and signed
//                overflow together with a one-cycle done pulse.
//  Ports       : i_clk    - clock, rising edge
//                i_rst    - synchronous active-high reset
//                i_start  - start request, honoured only in IDLE
//                i_a/i_b  - operands (WIDTH bits), i_cin - carry-in
//                o_busy   - high while bits are being added
//                o_done   - one-cycle result-valid pulse
//                o_sum    - (A+B+cin) mod 2^WIDTH, held until next result
//                o_cout   - carry out of the MSB
//                o_ovf    - two's-complement overflow
//  Revision    : 1.0  initial release
// ============================================================================
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int            c_CW   = cnt_width(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    state_t           r_state_q, w_state_d;
    logic [WIDTH-1:0] r_a_q,     w_a_d;
    logic [WIDTH-1:0] r_b_q,     w_b_d;
    logic [WIDTH-1:0] r_sum_q,   w_sum_d;
    logic [c_CW-1:0]  r_cnt_q,   w_cnt_d;
    logic             r_carry_q, w_carry_d;
    logic             r_cmsb_q,  w_cmsb_d;   // carry into the MSB slice
    logic [WIDTH-1:0] r_osum_q,  w_osum_d;
    logic             r_cout_q,  w_cout_d;
    logic             r_ovf_q,   w_ovf_d;
    logic             r_done_q,  w_done_d;

    logic             w_s;
    logic             w_c;

    full_adder_1 u_bit_slice (
        .i_a    (r_a_q[0]),
        .i_b    (r_b_q[0]),
        .i_Cin  (r_carry_q),
        .o_s    (w_s),
        .o_Cout (w_c)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q <= IDLE;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_sum_q   <= '0;
            r_cnt_q   <= '0;
            r_carry_q <= 1'b0;
            r_cmsb_q  <= 1'b0;
            r_osum_q  <= '0;
            r_cout_q  <= 1'b0;
            r_ovf_q   <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_sum_q   <= w_sum_d;
            r_cnt_q   <= w_cnt_d;
            r_carry_q <= w_carry_d;
            r_cmsb_q  <= w_cmsb_d;
            r_osum_q  <= w_osum_d;
            r_cout_q  <= w_cout_d;
            r_ovf_q   <= w_ovf_d;
            r_done_q  <= w_done_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_sum_d   = r_sum_q;
        w_cnt_d   = r_cnt_q;
        w_carry_d = r_carry_q;
        w_cmsb_d  = r_cmsb_q;
        w_osum_d  = r_osum_q;
        w_cout_d  = r_cout_q;
        w_ovf_d   = r_ovf_q;
        w_done_d  = 1'b0;

        case (r_state_q)
            IDLE: begin
                if (i_start) begin
                    w_a_d     = i_a;
                    w_b_d     = i_b;
                    w_carry_d = i_cin;
                    w_cnt_d   = '0;
                    w_sum_d   = '0;
                    w_state_d = RUN;
                end
            end
            RUN: begin
                w_a_d     = r_a_q >> 1;
                w_b_d     = r_b_q >> 1;
                // LSB-first: each new sum bit enters at the top, so after
                // WIDTH shifts bit 0 has migrated down to position 0.
                w_sum_d   = {w_s, r_sum_q[WIDTH-1:1]};
                w_carry_d = w_c;
                w_cnt_d   = r_cnt_q + c_CW'(1);
                if (r_cnt_q == c_LAST) begin
                    w_cmsb_d  = r_carry_q;
                    w_state_d = DONE;
                end
            end
            DONE: begin
                // Results and the done pulse become visible together.
                w_osum_d  = r_sum_q;
                w_cout_d  = r_carry_q;
                w_ovf_d   = r_cmsb_q ^ r_carry_q;
                w_done_d  = 1'b1;
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    assign o_busy = (r_state_q == RUN);
    assign o_done = r_done_q;
    assign o_sum  = r_osum_q;
    assign o_cout = r_cout_q;
    assign o_ovf  = r_ovf_q;

endmodule
`default_nettype wire
